freq_lock_ctrl: RTL and testbench

Sequencing controller for the function generator's frequency regulator. It accepts a target period over a valid/ready handshake and drives it to the regulator as `set_period`. It holds the regulator in reset while idle and during retune, then watches the sampled signal `psi` and the regulator's `duration` count. It declares lock after a run of consecutive in-tolerance measurement windows, and (optionally) fails after a timeout.

---
 rtl/freq_ctrl_pkg.sv | 42 ++++
 rtl/freq_lock_ctrl_psi_edge_detect.sv | 29 ++
 rtl/freq_lock_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_freq_lock_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// freq_ctrl_pkg
// Shared types and constants for the frequency-lock sequencing controller.
//   lock_state_t : controller FSM states
//   lock_dbg_t   : debug view of controller internals (state, armed, psi_q)
//   abs_diff     : wrap-free absolute difference of two DUR_W-bit values
// -----------------------------------------------------------------------------
package freq_ctrl_pkg;

    localparam int DUR_W        = 9;
    localparam int PER_W        = 8;
    localparam int GOOD_W       = 4;
    localparam int WIN_W        = 7;
    localparam int FLUSH_CYCLES = 2;

    localparam int DEF_TOL      = 2;
    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_MAX_WIN  = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        TRACK  = 3'd2,
        LOCKED = 3'd3,
        FAIL   = 3'd4
    } lock_state_t;

    typedef struct packed {
        lock_state_t state;
        logic        armed;
        logic        psi_q;
    } lock_dbg_t;

    // Compare first, then subtract the smaller from the larger so the result
    // never wraps.
    function automatic logic [DUR_W-1:0] abs_diff(input logic [DUR_W-1:0] a,
                                                  input logic [DUR_W-1:0] b);
        if (a >= b) return a - b;
        else        return b - a;
    endfunction

endpackage

// File: rtl/freq_lock_ctrl_psi_edge_detect.sv
// -----------------------------------------------------------------------------
// psi_edge_detect
// Registers the sampled regulator output psi and derives single-cycle edge
// pulses from the current sample and the registered one.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   psi      : sampled signal
//   rise     : ~psi_q & psi
//   fall     : psi_q & ~psi
//   psi_q    : psi delayed by one clock (reset 0)
// -----------------------------------------------------------------------------
module psi_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic psi,
    output logic rise,
    output logic fall,
    output logic psi_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) psi_q <= 1'b0;
        else     psi_q <= psi;
    end

    assign rise = ~psi_q & psi;
    assign fall = psi_q & ~psi;

endmodule

// File: rtl/freq_lock_ctrl.sv
// -----------------------------------------------------------------------------
// freq_lock_ctrl
// Sequencing controller for the function generator's frequency regulator.
// Accepts a target period over valid/ready, holds the regulator in reset while
// idle and for a fixed flush after every retune, then measures complete high
// phases of psi against the target and declares lock after LOCK_CNT
// consecutive in-tolerance windows.
//
// Optional feature macro: FREQ_LOCK_TIMEOUT_EN
//   defined   : TRACK counts valid windows; MAX_WIN windows without lock
//               moves to FAIL, which holds until the next accepted request.
//   undefined : no window counter, no FAIL entry; fail is tied 0.
//
// Handshake: a request transfers on any clock edge where req_valid and
// req_ready are both high; req_ready is low only while flushing, and
// req_valid may be raised or dropped at any time without further obligation.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   req_valid   : new target period offered
//   req_period  : target period (clk cycles of high phase)
//   req_ready   : request can be accepted (decoded from state)
//   psi         : sampled regulator output
//   duration    : regulator's high-phase count
//   set_period  : latched target period to the regulator
//   reg_rst     : regulator reset, active-high
//   locked      : lock achieved
//   fail        : lock timeout
//   good_cnt    : consecutive in-tolerance window count
//   dbg         : FSM state, armed flag and registered psi
// -----------------------------------------------------------------------------
module freq_lock_ctrl
    import freq_ctrl_pkg::*;
#(
    parameter int TOL      = DEF_TOL,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int MAX_WIN  = DEF_MAX_WIN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [PER_W-1:0]  req_period,
    output logic              req_ready,
    input  logic              psi,
    input  logic [DUR_W-1:0]  duration,
    output logic [PER_W-1:0]  set_period,
    output logic              reg_rst,
    output logic              locked,
    output logic              fail,
    output logic [GOOD_W-1:0] good_cnt,
    output lock_dbg_t         dbg
);

    // Reject out-of-range configurations at elaboration.
    if (TOL < 0 || TOL > 255)          begin : g_bad_tol      $error("TOL out of range");      end
    if (LOCK_CNT < 1 || LOCK_CNT > 15) begin : g_bad_lock_cnt $error("LOCK_CNT out of range"); end
    if (MAX_WIN < 1 || MAX_WIN > 127)  begin : g_bad_max_win  $error("MAX_WIN out of range");  end

    localparam logic [DUR_W-1:0]  TOL_V      = DUR_W'(TOL);
    localparam logic [GOOD_W-1:0] LOCK_CNT_V = GOOD_W'(LOCK_CNT);
    localparam logic [GOOD_W-1:0] GOOD_MAX   = {GOOD_W{1'b1}};
    localparam logic [1:0]        FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

    lock_state_t       state;
    logic [1:0]        flush_cnt;
    logic              armed;
    logic              rise;
    logic              fall;
    logic              psi_q;

    logic              accept;
    logic              valid_win;
    logic [DUR_W-1:0]  err;
    logic              win_good;
    logic [GOOD_W-1:0] good_inc;

    psi_edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .psi   (psi),
        .rise  (rise),
        .fall  (fall),
        .psi_q (psi_q)
    );

    assign req_ready = (state != FLUSH);
    assign accept    = req_valid && req_ready;

    // Only a fall that closes an armed high phase is a measurement; the
    // partial phase left over from the flush is discarded.
    assign valid_win = fall && armed && (state == TRACK || state == LOCKED);

    assign err      = abs_diff(duration, {1'b0, set_period});
    assign win_good = (err <= TOL_V);
    assign good_inc = (good_cnt == GOOD_MAX) ? GOOD_MAX : good_cnt + 1'b1;

    assign dbg = '{state: state, armed: armed, psi_q: psi_q};

`ifdef FREQ_LOCK_TIMEOUT_EN
    localparam logic [WIN_W-1:0] MAX_WIN_V = WIN_W'(MAX_WIN);

    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_next;
    logic             fail_q;

    assign win_next = win_cnt + 1'b1;
    assign fail     = fail_q;
`else
    assign fail = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            flush_cnt  <= '0;
            armed      <= 1'b0;
            set_period <= '0;
            reg_rst    <= 1'b1;
            locked     <= 1'b0;
            good_cnt   <= '0;
`ifdef FREQ_LOCK_TIMEOUT_EN
            win_cnt    <= '0;
            fail_q     <= 1'b0;
`endif
        end else if (accept) begin
            // A request always wins; any window closing this cycle is dropped.
            state      <= FLUSH;
            flush_cnt  <= '0;
            armed      <= 1'b0;
            set_period <= req_period;
            reg_rst    <= 1'b1;
            locked     <= 1'b0;
            good_cnt   <= '0;
`ifdef FREQ_LOCK_TIMEOUT_EN
            win_cnt    <= '0;
            fail_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    reg_rst <= 1'b1;
                end

                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state   <= TRACK;
                        reg_rst <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end

                TRACK: begin
                    if (rise) begin
                        armed <= 1'b1;
                    end else if (valid_win) begin
                        armed    <= 1'b0;
                        good_cnt <= win_good ? good_inc : '0;
`ifdef FREQ_LOCK_TIMEOUT_EN
                        win_cnt  <= win_next;
`endif
                        // Lock takes priority over a timeout on the same window.
                        if (win_good && good_inc >= LOCK_CNT_V) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
`ifdef FREQ_LOCK_TIMEOUT_EN
                        else if (win_next >= MAX_WIN_V) begin
                            state   <= FAIL;
                            reg_rst <= 1'b1;
                            fail_q  <= 1'b1;
                        end
`endif
                    end
                end

                LOCKED: begin
                    if (rise) begin
                        armed <= 1'b1;
                    end else if (valid_win) begin
                        armed <= 1'b0;
                        if (win_good) begin
                            good_cnt <= good_inc;
                        end else begin
                            state    <= TRACK;
                            locked   <= 1'b0;
                            good_cnt <= '0;
`ifdef FREQ_LOCK_TIMEOUT_EN
                            win_cnt  <= '0;
`endif
                        end
                    end
                end

                FAIL: begin
                    reg_rst <= 1'b1;
                end

                default: begin
                    state   <= IDLE;
                    reg_rst <= 1'b1;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_lock_ctrl.sv
module tb_freq_lock_ctrl;
  import freq_ctrl_pkg::*;

  localparam int TOL      = 2;
  localparam int LOCK_CNT = 4;
  localparam int MAX_WIN  = 8;

  // ---------------------------------------------------------------- clock/reset
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [7:0]       req_period = '0;
  logic             req_ready;
  logic             psi = 1'b0;
  logic [8:0]       duration = '0;
  logic [7:0]       set_period;
  logic             reg_rst;
  logic             locked;
  logic             fail;
  logic [3:0]       good_cnt;
  lock_dbg_t        dbg;

  always #5 clk = ~clk;

  freq_lock_ctrl #(.TOL(TOL), .LOCK_CNT(LOCK_CNT), .MAX_WIN(MAX_WIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_period (req_period),
    .req_ready  (req_ready),
    .psi        (psi),
    .duration   (duration),
    .set_period (set_period),
    .reg_rst    (reg_rst),
    .locked     (locked),
    .fail       (fail),
    .good_cnt   (good_cnt),
    .dbg        (dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  // entry = {fail, locked, good_cnt}
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  int m_target = 0;
  int m_good   = 0;
  int m_win    = 0;
  bit m_locked = 0;
  bit m_fail   = 0;

  function automatic void model_clear(input int target);
    m_target = target;
    m_good   = 0;
    m_win    = 0;
    m_locked = 0;
    m_fail   = 0;
  endfunction

  function automatic void model_window(input int dur);
    int err;
    bit good;
    err  = (dur >= m_target) ? dur - m_target : m_target - dur;
    good = (err <= TOL);
    if (m_locked) begin
      if (good) m_good = (m_good == 15) ? 15 : m_good + 1;
      else begin
        m_locked = 0;
        m_good   = 0;
        m_win    = 0;
      end
    end else begin
      m_good = good ? ((m_good == 15) ? 15 : m_good + 1) : 0;
      m_win++;
      if (m_good >= LOCK_CNT) m_locked = 1;
`ifdef FREQ_LOCK_TIMEOUT_EN
      else if (m_win >= MAX_WIN) m_fail = 1;
`endif
    end
    exp_q.push_back({m_fail, m_locked, 4'(m_good)});
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic do_request(input logic [7:0] p);
    @(negedge clk);
    req_valid  = 1'b1;
    req_period = p;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL req_ready_before got=%0b want=1", req_ready);
    else n_pass++;
    model_clear(int'(p));
    @(negedge clk);  // cycle T+1
    req_valid = 1'b0;
    n_checks++;
    if (set_period !== p) $display("FAIL set_period got=%0d want=%0d", set_period, p);
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b0 || reg_rst !== 1'b1 || dbg.state !== FLUSH)
      $display("FAIL flush_t1 ready=%0b reg_rst=%0b state=%0d want 0/1/%0d",
               req_ready, reg_rst, dbg.state, FLUSH);
    else n_pass++;
    n_checks++;
    if (locked !== 1'b0 || fail !== 1'b0 || good_cnt !== 4'd0)
      $display("FAIL flush_clear locked=%0b fail=%0b good=%0d want 0/0/0", locked, fail, good_cnt);
    else n_pass++;
    @(negedge clk);  // cycle T+2
    n_checks++;
    if (req_ready !== 1'b0 || reg_rst !== 1'b1)
      $display("FAIL flush_t2 ready=%0b reg_rst=%0b want 0/1", req_ready, reg_rst);
    else n_pass++;
    @(negedge clk);  // cycle T+3
    n_checks++;
    if (req_ready !== 1'b1 || reg_rst !== 1'b0 || dbg.state !== TRACK)
      $display("FAIL track_t3 ready=%0b reg_rst=%0b state=%0d want 1/0/%0d",
               req_ready, reg_rst, dbg.state, TRACK);
    else n_pass++;
  endtask

  // One armed high phase of hi cycles, closing with the given duration.
  task automatic window(input logic [8:0] dur, input int hi);
    logic [5:0] e;
    @(negedge clk);
    psi = 1'b1;
    repeat (hi - 1) @(negedge clk);
    psi      = 1'b0;
    duration = dur;
    model_window(int'(dur));
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (good_cnt !== e[3:0]) $display("FAIL good_cnt dur=%0d got=%0d want=%0d", dur, good_cnt, e[3:0]);
    else n_pass++;
    n_checks++;
    if (locked !== e[4]) $display("FAIL locked dur=%0d got=%0b want=%0b", dur, locked, e[4]);
    else n_pass++;
    n_checks++;
    if (fail !== e[5]) $display("FAIL fail dur=%0d got=%0b want=%0b", dur, fail, e[5]);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dbg.state !== IDLE || reg_rst !== 1'b1 || req_ready !== 1'b1 || set_period !== 8'h00 ||
        locked !== 1'b0 || fail !== 1'b0 || good_cnt !== 4'd0 || dbg.armed !== 1'b0 || dbg.psi_q !== 1'b0)
      $display("FAIL reset_values state=%0d reg_rst=%0b ready=%0b set=%0d locked=%0b fail=%0b good=%0d",
               dbg.state, reg_rst, req_ready, set_period, locked, fail, good_cnt);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dbg.state !== IDLE || reg_rst !== 1'b1)
      $display("FAIL idle_hold state=%0d reg_rst=%0b want %0d/1", dbg.state, reg_rst, IDLE);
    else n_pass++;
  endtask

  task automatic test_lock();
    psi = 1'b1;  // high through the flush: first phase in TRACK is partial
    do_request(8'd10);
    @(negedge clk);
    psi      = 1'b0;
    duration = 9'd10;
    @(negedge clk);
    n_checks++;
    if (good_cnt !== 4'd0 || dbg.state !== TRACK)
      $display("FAIL partial_phase good=%0d state=%0d want 0/%0d", good_cnt, dbg.state, TRACK);
    else n_pass++;
    window(9'd10, 3);
    window(9'd11, 4);
    window(9'd9, 3);
    window(9'd10, 3);
    n_checks++;
    if (dbg.state !== LOCKED) $display("FAIL lock_state got=%0d want=%0d", dbg.state, LOCKED);
    else n_pass++;
    window(9'd10, 2);  // stays locked, count keeps climbing
  endtask

  task automatic test_unlock();
    window(9'd14, 3);
    n_checks++;
    if (dbg.state !== TRACK) $display("FAIL unlock_state got=%0d want=%0d", dbg.state, TRACK);
    else n_pass++;
  endtask

  task automatic test_tolerance();
    window(9'd12, 3);   // err 2: in tolerance
    window(9'd8, 3);    // err 2: in tolerance
    window(9'd13, 3);   // err 3: out
    window(9'd7, 3);    // err 3: out
    window(9'd511, 3);  // far above, must not wrap to small
    window(9'd10, 3);
  endtask

  task automatic test_random();
    do_request(8'd10);
    for (int i = 0; i < 6; i++)
      window(9'($urandom_range(6, 14)), int'($urandom_range(2, 5)));
  endtask

  task automatic test_back_to_back();
    window(9'd10, 3);
    window(9'd10, 3);
    @(negedge clk);
    psi = 1'b1;
    repeat (2) @(negedge clk);
    psi        = 1'b0;
    duration   = 9'd10;
    req_valid  = 1'b1;
    req_period = 8'd12;
    @(negedge clk);
    req_valid = 1'b0;
    model_clear(12);
    n_checks++;
    if (good_cnt !== 4'd0 || dbg.state !== FLUSH || set_period !== 8'd12 || locked !== 1'b0)
      $display("FAIL collide good=%0d state=%0d set=%0d locked=%0b want 0/%0d/12/0",
               good_cnt, dbg.state, set_period, locked, FLUSH);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dbg.state !== TRACK || reg_rst !== 1'b0)
      $display("FAIL collide_track state=%0d reg_rst=%0b want %0d/0", dbg.state, reg_rst, TRACK);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_request(8'd10);
    for (int i = 0; i < MAX_WIN + 2; i++) begin
      window(9'd20, 3);
      if (m_fail) break;
    end
`ifdef FREQ_LOCK_TIMEOUT_EN
    n_checks++;
    if (dbg.state !== FAIL || reg_rst !== 1'b1 || fail !== 1'b1)
      $display("FAIL timeout state=%0d reg_rst=%0b fail=%0b want %0d/1/1", dbg.state, reg_rst, fail, FAIL);
    else n_pass++;
    do_request(8'd20);
    n_checks++;
    if (fail !== 1'b0) $display("FAIL fail_clear got=%0b want=0", fail);
    else n_pass++;
`else
    n_checks++;
    if (dbg.state !== TRACK || fail !== 1'b0 || reg_rst !== 1'b0)
      $display("FAIL no_timeout state=%0d fail=%0b reg_rst=%0b want %0d/0/0", dbg.state, fail, reg_rst, TRACK);
    else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    do_request(8'd10);
    for (int i = 0; i < LOCK_CNT; i++) window(9'd10, 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (locked !== 1'b0 || reg_rst !== 1'b1 || set_period !== 8'h00 || good_cnt !== 4'd0 ||
        dbg.state !== IDLE || req_ready !== 1'b1)
      $display("FAIL async_rst locked=%0b reg_rst=%0b set=%0d good=%0d state=%0d ready=%0b",
               locked, reg_rst, set_period, good_cnt, dbg.state, req_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    test_reset();
    test_lock();
    test_unlock();
    test_tolerance();
    test_random();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
